// File: rtl/multi_channel_packer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_packer
// Brief    : Compacts a sparse input lane bundle into a contiguous prefix and
//            drains it OUT_PORTS_NUM lanes per beat under an all-or-nothing
//            ready. Optional same-cycle bypass: MC_PACKER_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_packer #(
    parameter int IN_PORTS_NUM  = 8,
    parameter int OUT_PORTS_NUM = 4,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                clk,
    input  logic                                a_rst_n,
    input  logic                                flush_i,
    input  logic [IN_PORTS_NUM-1:0]             in_valid_i,
    output logic                                in_ready_o,
    input  logic [IN_PORTS_NUM*DATA_WIDTH-1:0]  in_data_i,
    output logic [OUT_PORTS_NUM-1:0]            out_valid_o,
    input  logic                                out_ready_i,
    output logic [OUT_PORTS_NUM*DATA_WIDTH-1:0] out_data_o
);

    localparam int CW = $clog2(IN_PORTS_NUM + 1);
    localparam int HW = $clog2(IN_PORTS_NUM);

    logic [CW-1:0]         rem_cnt;
    logic [HW-1:0]         head;
    logic [DATA_WIDTH-1:0] lane_buf [IN_PORTS_NUM];
    logic [DATA_WIDTH-1:0] comp     [IN_PORTS_NUM];
    logic [CW-1:0]         in_cnt;
    logic [CW-1:0]         beat_n;
    logic                  fire;
    logic                  accept;
    logic                  load;

    // Compaction: the i-th set input lane lands in comp[i]; in_cnt ends as popcount.
    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < IN_PORTS_NUM; i++) begin
            comp[i] = '0;
        end
        for (int i = 0; i < IN_PORTS_NUM; i++) begin
            if (in_valid_i[i]) begin
                comp[in_cnt[HW-1:0]] = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                in_cnt               = in_cnt + CW'(1);
            end
        end
    end

    assign beat_n     = (rem_cnt > CW'(OUT_PORTS_NUM)) ? CW'(OUT_PORTS_NUM) : rem_cnt;
    assign fire       = out_ready_i & (rem_cnt != '0);
    assign in_ready_o = (rem_cnt == '0) | (out_ready_i & (rem_cnt <= CW'(OUT_PORTS_NUM)));
    assign accept     = in_ready_o & (|in_valid_i) & ~flush_i;

`ifdef MC_PACKER_BYPASS_EN
    logic bypass;
    // Small bundle into an idle packer with a ready sink skips the buffer entirely.
    assign bypass = (rem_cnt == '0) & out_ready_i & ~flush_i &
                    (in_cnt != '0) & (in_cnt <= CW'(OUT_PORTS_NUM));
    assign load   = accept & ~bypass;
`else
    assign load   = accept;
`endif

    for (genvar j = 0; j < OUT_PORTS_NUM; j++) begin : g_out
        logic [HW-1:0] idx;
        assign idx = head + HW'(j);
`ifdef MC_PACKER_BYPASS_EN
        assign out_valid_o[j] = bypass ? (CW'(j) < in_cnt) : (CW'(j) < beat_n);
        assign out_data_o[j*DATA_WIDTH +: DATA_WIDTH] = bypass ? comp[j] : lane_buf[idx];
`else
        assign out_valid_o[j] = (CW'(j) < beat_n);
        assign out_data_o[j*DATA_WIDTH +: DATA_WIDTH] = lane_buf[idx];
`endif
    end

    // A fresh load overrides the drain update, giving last-beat-plus-refill.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            rem_cnt <= '0;
            head    <= '0;
        end else if (flush_i) begin
            rem_cnt <= '0;
            head    <= '0;
        end else if (load) begin
            rem_cnt <= in_cnt;
            head    <= '0;
        end else if (fire) begin
            rem_cnt <= rem_cnt - beat_n;
            head    <= head + HW'(beat_n);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < IN_PORTS_NUM; i++) begin
                lane_buf[i] <= comp[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_packer
// Brief    : Directed self-checking bench for multi_channel_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_packer;

    localparam int IN_N  = 8;
    localparam int OUT_N = 4;
    localparam int DW    = 32;

    logic                 clk = 1'b0;
    logic                 a_rst_n;
    logic                 flush_i;
    logic [IN_N-1:0]      in_valid_i;
    logic                 in_ready_o;
    logic [IN_N*DW-1:0]   in_data_i;
    logic [OUT_N-1:0]     out_valid_o;
    logic                 out_ready_i;
    logic [OUT_N*DW-1:0]  out_data_o;

    int passed = 0;
    int total  = 0;

    multi_channel_packer #(
        .IN_PORTS_NUM (IN_N),
        .OUT_PORTS_NUM(OUT_N),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk        (clk),
        .a_rst_n    (a_rst_n),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic set_data(input logic [DW-1:0] base);
        for (int i = 0; i < IN_N; i++) begin
            in_data_i[i*DW +: DW] = base + DW'(i);
        end
    endtask

    function automatic logic [DW-1:0] lane(input int j);
        return out_data_o[j*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = '0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'h0);
        chk("rst_in_ready", 64'(in_ready_o), 64'h1);
        a_rst_n = 1'b1;
        tick();

        // Sparse bundle 1010_0101 compacts to lanes 0,2,5,7
        in_valid_i  = 8'b1010_0101;
        set_data(32'h100);
        out_ready_i = 1'b1;
        #1;
        chk("sparse_in_ready_pre", 64'(in_ready_o), 64'h1);
        tick();
        in_valid_i = '0;
        #1;
        chk("sparse_valid", 64'(out_valid_o), 64'hF);
        chk("sparse_d0", 64'(lane(0)), 64'h100);
        chk("sparse_d1", 64'(lane(1)), 64'h102);
        chk("sparse_d2", 64'(lane(2)), 64'h105);
        chk("sparse_d3", 64'(lane(3)), 64'h107);
        chk("sparse_in_ready", 64'(in_ready_o), 64'h1);
        tick();
        chk("sparse_drained", 64'(out_valid_o), 64'h0);

        // Full bundle: two beats, refill accepted during the second beat
        in_valid_i = 8'hFF;
        set_data(32'h200);
        tick();
        in_valid_i = '0;
        #1;
        chk("full_b1_valid", 64'(out_valid_o), 64'hF);
        chk("full_b1_d0", 64'(lane(0)), 64'h200);
        chk("full_b1_d3", 64'(lane(3)), 64'h203);
        chk("full_b1_in_ready", 64'(in_ready_o), 64'h0);
        tick();
        in_valid_i = 8'h03;
        set_data(32'h300);
        #1;
        chk("full_b2_valid", 64'(out_valid_o), 64'hF);
        chk("full_b2_d0", 64'(lane(0)), 64'h204);
        chk("full_b2_d3", 64'(lane(3)), 64'h207);
        chk("full_b2_in_ready", 64'(in_ready_o), 64'h1);
        tick();
        in_valid_i = '0;
        #1;
        chk("refill_valid", 64'(out_valid_o), 64'h3);
        chk("refill_d0", 64'(lane(0)), 64'h300);
        chk("refill_d1", 64'(lane(1)), 64'h301);
        tick();
        chk("refill_drained", 64'(out_valid_o), 64'h0);

        // Backpressure with 3 lanes (1,2,4); a bundle offered meanwhile is refused
        out_ready_i = 1'b0;
        in_valid_i  = 8'b0001_0110;
        set_data(32'h400);
        tick();
        in_valid_i = 8'hFF;
        set_data(32'h900);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", 64'(out_valid_o), 64'h7);
            chk("bp_d0", 64'(lane(0)), 64'h401);
            chk("bp_d1", 64'(lane(1)), 64'h402);
            chk("bp_d2", 64'(lane(2)), 64'h404);
            chk("bp_in_ready", 64'(in_ready_o), 64'h0);
            tick();
        end
        in_valid_i  = '0;
        out_ready_i = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready_o), 64'h1);
        tick();
        chk("bp_one_beat", 64'(out_valid_o), 64'h0);

        // Idle with no valid lanes, then a single lane-7 bundle
        tick();
        tick();
        chk("idle_valid", 64'(out_valid_o), 64'h0);
        chk("idle_in_ready", 64'(in_ready_o), 64'h1);
        in_valid_i = 8'h80;
        set_data(32'h500);
        tick();
        in_valid_i = '0;
        #1;
        chk("lane7_valid", 64'(out_valid_o), 64'h1);
        chk("lane7_d0", 64'(lane(0)), 64'h507);
        tick();

        // Flush during the second beat; input presented in the flush cycle is dropped
        in_valid_i = 8'hFF;
        set_data(32'h600);
        tick();
        in_valid_i = '0;
        #1;
        chk("flush_b1_d0", 64'(lane(0)), 64'h600);
        tick();
        flush_i    = 1'b1;
        in_valid_i = 8'h0F;
        set_data(32'h700);
        #1;
        chk("flush_b2_d0", 64'(lane(0)), 64'h604);
        tick();
        flush_i    = 1'b0;
        in_valid_i = '0;
        #1;
        chk("post_flush_valid", 64'(out_valid_o), 64'h0);
        chk("post_flush_in_ready", 64'(in_ready_o), 64'h1);
        tick();
        chk("flush_input_dropped", 64'(out_valid_o), 64'h0);

        // Asynchronous reset mid-drain discards the buffered bundle
        in_valid_i  = 8'hFF;
        out_ready_i = 1'b0;
        set_data(32'h800);
        tick();
        in_valid_i = '0;
        #1;
        chk("pre_arst_valid", 64'(out_valid_o), 64'hF);
        #2;
        a_rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid_o), 64'h0);
        chk("arst_in_ready", 64'(in_ready_o), 64'h1);
        a_rst_n     = 1'b1;
        out_ready_i = 1'b1;
        tick();

        // Two-lane bundle into an idle packer: same-cycle only with bypass
        in_valid_i = 8'b0000_0011;
        set_data(32'hA00);
        #1;
`ifdef MC_PACKER_BYPASS_EN
        chk("bypass_same_valid", 64'(out_valid_o), 64'h3);
        chk("bypass_same_d1", 64'(lane(1)), 64'hA01);
        tick();
        in_valid_i = '0;
        #1;
        chk("bypass_next_valid", 64'(out_valid_o), 64'h0);
`else
        chk("nobypass_same_valid", 64'(out_valid_o), 64'h0);
        tick();
        in_valid_i = '0;
        #1;
        chk("nobypass_next_valid", 64'(out_valid_o), 64'h3);
        chk("nobypass_next_d1", 64'(lane(1)), 64'hA01);
`endif
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/multi_channel_packer.md
# multi_channel_packer

Write-side front end for the multi-channel FIFO. It accepts a bundle of up to IN_PORTS_NUM lanes with an arbitrary (sparse) valid mask and compacts the valid lanes into a contiguous prefix starting at lane [0]. It then emits them OUT_PORTS_NUM at a time, in order, under an all-or-nothing ready. This is the only contiguous-prefix form the FIFO write port accepts. Typical placement: between decode/rename lane outputs and the multi-channel FIFO write port.

## Interface
- IN_PORTS_NUM, 8, input lanes per bundle (power of two, ≥2)
- OUT_PORTS_NUM, 4, output lanes per beat (power of two, ≤ IN_PORTS_NUM)
- DATA_WIDTH, 32, bits per lane
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all buffered lanes
- in_valid_i  in  IN_PORTS_NUM  per-lane valid; any pattern allowed
- in_ready_o  out  1  bundle accepted this cycle when high and |in_valid_i
- in_data_i  in  IN_PORTS_NUM×DATA_WIDTH  lane data
- out_valid_o  out  OUT_PORTS_NUM  contiguous-from-[0] valid mask
- out_ready_i  in  1  downstream accepts all asserted out lanes (all-or-nothing)
- out_data_o  out  OUT_PORTS_NUM×DATA_WIDTH  compacted data

## Operation
- State:
  - buf: IN_PORTS_NUM lanes of data.
  - rem_cnt: 0..IN_PORTS_NUM, width $clog2(IN_PORTS_NUM+1).
  - head: 0..IN_PORTS_NUM−1, width $clog2(IN_PORTS_NUM).
- States:
  - EMPTY (rem_cnt==0).
  - DRAIN (rem_cnt>0).
- Beat size: n = min(rem_cnt, OUT_PORTS_NUM).
  - out_valid_o[j] = (j < n).
  - out_data_o[j] = buf[head+j]. head+j never exceeds IN_PORTS_NUM−1 because rem_cnt bounds it.
- Output handshake: when out_ready_i & (rem_cnt>0), the beat fires. head += n, rem_cnt −= n.
- in_ready_o = (rem_cnt==0) | (out_ready_i & rem_cnt ≤ OUT_PORTS_NUM). This is combinational from out_ready_i.
- Input accept: when in_ready_o & |in_valid_i:
  - k = popcount(in_valid_i).
  - The i-th set lane (ascending index) goes to buf[i].
  - rem_cnt ← k, head ← 0.
  - This overrides the drain update in the same cycle, which is a simultaneous last-beat plus refill.
- in_valid_i == 0 is a no-op: no state change, regardless of in_ready_o.
- Lane order is preserved: lower input index is emitted first, and bundles are emitted in acceptance order.
- A bundle with k lanes takes ceil(k/OUT_PORTS_NUM) beats. No beat ever mixes lanes from two bundles.
- flush_i: rem_cnt ← 0, head ← 0. Input is ignored in the flush cycle and no output beat fires.
- Reset values:
  - rem_cnt = 0, head = 0.
  - out_valid_o = 0, in_ready_o = 1.
  - buf contents are don't-care.
- Reset asserted mid-drain discards all buffered lanes immediately (asynchronous).

## Timing
- Latency: an accepted bundle appears on out_valid_o the next cycle. This is 0 cycles under bypass; see Configuration.
- Throughput:
  - One bundle per cycle when k ≤ OUT_PORTS_NUM and out_ready_i is held high.
  - Otherwise one bundle per ceil(k/OUT_PORTS_NUM) cycles.
- out_valid_o and out_data_o are stable while out_ready_i is low. Valid never drops without a handshake, except on flush or reset.
- in_ready_o may rise combinationally with out_ready_i. No combinational path from in_valid_i to out_* exists, except under bypass.

## Configuration
- MC_PACKER_BYPASS_EN defined:
  - When rem_cnt==0, out_ready_i is high and 0 < k ≤ OUT_PORTS_NUM, the compacted input drives out_* in the same cycle.
  - The bundle is consumed without touching buf; rem_cnt stays 0.
  - If out_ready_i is low or k > OUT_PORTS_NUM, the bundle is registered as normal.
- Not defined: out_* come only from buf; latency is always 1 cycle.

## Test plan
- Reset, then in_valid_i=8'b1010_0101 with data lane i = 0x100+i, out_ready_i=1:
  - Next cycle out_valid_o=4'b1111 with data 0x100, 0x102, 0x105, 0x107.
  - in_ready_o=1 throughout.
- in_valid_i=8'hFF with out_ready_i=1:
  - Beat 1 carries lanes 0–3; beat 2 carries lanes 4–7.
  - in_ready_o=0 during beat 1 and 1 during beat 2.
  - A second bundle presented in beat 2 is accepted and appears in beat 3.
- Backpressure: load 3 lanes, hold out_ready_i=0 for 5 cycles.
  - out_valid_o=4'b0111 with unchanged data, in_ready_o=0.
  - After releasing out_ready_i, exactly one beat fires.
- in_valid_i=0 while in EMPTY: out_valid_o stays 0 and state is unchanged. Then a single-lane bundle on lane 7: out_valid_o=4'b0001 with lane-7 data.
- flush_i asserted during the second beat of an 8-lane bundle: next cycle out_valid_o=0 and in_ready_o=1. An input in the flush cycle is dropped.
- With MC_PACKER_BYPASS_EN, in_valid_i=8'b0000_0011 and out_ready_i=1 in EMPTY: out_valid_o=4'b0011 in the same cycle. Next cycle out_valid_o=0.
